// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling UART receiver with a two-flop rx synchronizer.
// Defining UART_RX_PARITY_EN adds an even-parity bit after the data bits.
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            parity_err,
   output logic            busy
);
   localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam logic [SW-1:0] S_MID  = SW'(7);
   localparam logic [SW-1:0] S_END  = SW'(15);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state;
   logic [SW-1:0]   s;
   logic [2:0]      n;
   logic [DBIT-1:0] b;
   logic            rx_meta;
   logic            rx_sync;
   logic            rx_prev;
`ifdef UART_RX_PARITY_EN
   logic            par_bit;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         rx_meta      <= 1'b1;
         rx_sync      <= 1'b1;
         rx_prev      <= 1'b1;
         rx_data      <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err   <= 1'b0;
         par_bit      <= 1'b0;
`endif
      end else begin
         rx_meta      <= rx;
         rx_sync      <= rx_meta;
         rx_prev      <= rx_sync;
         rx_done_tick <= 1'b0;
         case (state)
            // Edge detect runs every clk so a held-low line cannot retrigger.
            IDLE: begin
               if (rx_prev && !rx_sync) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s == S_MID) begin
                     if (!rx_sync) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s == S_END) begin
                     s <= '0;
                     b <= {rx_sync, b[DBIT-1:1]};
                     if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s == S_END) begin
                     s       <= '0;
                     par_bit <= rx_sync;
                     state   <= STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s == S_STOP) begin
                     state        <= IDLE;
                     s            <= '0;
                     rx_data      <= b;
                     frame_err    <= !rx_sync;
                     rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err   <= (^b) ^ par_bit;
`endif
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed frames against a frame-level model of uart_rx.
// Parity frames are added when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
   localparam int BIT_CLKS = 256;

   logic       clk;
   logic       reset;
   logic       s_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
      .clk(clk),
      .reset(reset),
      .s_tick(s_tick),
      .rx(rx),
      .rx_data(rx_data),
      .rx_done_tick(rx_done_tick),
      .frame_err(frame_err),
      .parity_err(parity_err),
      .busy(busy)
   );

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         done_cnt = 0;
   int         tcnt = 0;
   bit         started = 0;
   logic       reset_q = 1'b1;
   logic       prev_done = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       m_ferr = 1'b0;
   logic       m_perr = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      tcnt   = (tcnt + 1) % 16;
      s_tick = (tcnt == 0);
   end

   always @(posedge clk) reset_q <= reset;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Frame-level model: a done pulse must match the oldest expected frame,
   // and outputs must hold the last delivered values every other cycle.
   always @(negedge clk) begin
      if (started) begin
         if (reset_q) begin
            m_data = 8'h00;
            m_ferr = 1'b0;
            m_perr = 1'b0;
            chk("done_in_reset", rx_done_tick, 1'b0);
         end else if (rx_done_tick === 1'b1) begin
            done_cnt++;
            chk("done_width", prev_done, 1'b0);
            chk("done_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               m_data = e.d;
               m_ferr = e.fe;
               m_perr = e.pe;
            end
         end
         prev_done = rx_done_tick;
         chk("rx_data_hold", rx_data, m_data);
         chk("frame_err_hold", frame_err, m_ferr);
         chk("parity_err_hold", parity_err, m_perr);
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      wait_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic pbit);
      exp_t e;
      e.d  = d;
      e.fe = !stop_bit;
`ifdef UART_RX_PARITY_EN
      e.pe = (^d) ^ pbit;
`else
      e.pe = 1'b0;
`endif
      exp_q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(pbit);
`endif
      send_bit(stop_bit);
      rx = 1'b1;
   endtask

   initial begin
      int d0;
      reset  = 1'b1;
      rx     = 1'b1;
      s_tick = 1'b0;
      wait_clks(3);
      @(negedge clk);
      chk("reset_rx_data", rx_data, 8'h00);
      chk("reset_done", rx_done_tick, 1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_parity_err", parity_err, 1'b0);
      chk("reset_busy", busy, 1'b0);
      started = 1;
      wait_clks(1);
      reset = 1'b0;
      wait_clks(40);

      d0 = done_cnt;
      send_frame(8'h55, 1'b1, 1'b0);
      wait_clks(64);
      chk("f55_done_count", done_cnt - d0, 1);
      chk("f55_rx_data", rx_data, 8'h55);
      chk("f55_frame_err", frame_err, 1'b0);
      chk("f55_busy_after", busy, 1'b0);

      d0 = done_cnt;
      rx = 1'b0;
      wait_clks(4 * 16);
      rx = 1'b1;
      wait_clks(BIT_CLKS * 2);
      chk("glitch_done_count", done_cnt - d0, 0);
      chk("glitch_busy", busy, 1'b0);
      chk("glitch_rx_data", rx_data, 8'h55);

      d0 = done_cnt;
      send_frame(8'hA3, 1'b0, 1'b0);
      wait_clks(64);
      chk("fa3_done_count", done_cnt - d0, 1);
      chk("fa3_rx_data", rx_data, 8'hA3);
      chk("fa3_frame_err", frame_err, 1'b1);
      chk("fa3_busy_after", busy, 1'b0);

      d0 = done_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      chk("abort_busy_before", busy, 1'b1);
      rx    = 1'b1;
      reset = 1'b1;
      wait_clks(2);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_rx_data", rx_data, 8'h00);
      chk("abort_frame_err", frame_err, 1'b0);
      chk("abort_parity_err", parity_err, 1'b0);
      chk("abort_busy", busy, 1'b0);
      wait_clks(BIT_CLKS * 7);
      chk("abort_done_count", done_cnt - d0, 0);
      chk("abort_busy_later", busy, 1'b0);

      d0 = done_cnt;
      send_frame(8'h0F, 1'b1, 1'b0);
      wait_clks(64);
      chk("f0f_done_count", done_cnt - d0, 1);
      chk("f0f_rx_data", rx_data, 8'h0F);

      d0 = done_cnt;
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      wait_clks(64);
      chk("b2b_done_count", done_cnt - d0, 2);
      chk("b2b_rx_data", rx_data, 8'hFF);
      chk("b2b_frame_err", frame_err, 1'b0);
      chk("b2b_busy_after", busy, 1'b0);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      wait_clks(64);
      chk("par_good_data", rx_data, 8'h07);
      chk("par_good_err", parity_err, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_clks(64);
      chk("par_bad_data", rx_data, 8'h07);
      chk("par_bad_err", parity_err, 1'b1);
`endif

      chk("all_frames_delivered", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
